// File: rtl/mult_control.sv
// Control FSM for an 8x8 multiplier built from one 4x4 multiplier and a shifting accumulator.
// Optional ERR state enabled by defining MULT_CONTROL_ERR_EN; otherwise violations return to IDLE.
module mult_control (
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  input  logic [1:0] count,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic [2:0] state_out,
  output logic       done,
  output logic       clk_ena,
  output logic       sclr_n
);

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StLsb      = 3'b001,
    StMid      = 3'b010,
    StMsb      = 3'b011,
    StCalcDone = 3'b100,
    StErr      = 3'b101
  } state_e;

`ifdef MULT_CONTROL_ERR_EN
  localparam state_e FailState = StErr;
`else
  localparam state_e FailState = StIdle;
`endif

  state_e r_state;
  state_e w_state_d;

  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    input_sel = 2'b00;
    shift_sel = 2'b00;
    done      = 1'b0;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    state_out = r_state;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StLsb;
          clk_ena   = 1'b1;
          sclr_n    = 1'b0;
        end
      end
      StLsb: begin
        if (!start && count == 2'b00) begin
          w_state_d = StMid;
          clk_ena   = 1'b1;
        end else begin
          w_state_d = FailState;
        end
      end
      StMid: begin
        if (!start && count == 2'b01) begin
          w_state_d = StMid;
          input_sel = 2'b01;
          shift_sel = 2'b01;
          clk_ena   = 1'b1;
        end else if (!start && count == 2'b10) begin
          w_state_d = StMsb;
          input_sel = 2'b10;
          shift_sel = 2'b01;
          clk_ena   = 1'b1;
        end else begin
          w_state_d = FailState;
        end
      end
      StMsb: begin
        if (!start && count == 2'b11) begin
          w_state_d = StCalcDone;
          input_sel = 2'b11;
          shift_sel = 2'b10;
          clk_ena   = 1'b1;
        end else begin
          w_state_d = FailState;
        end
      end
      StCalcDone: begin
        if (!start) begin
          w_state_d = StIdle;
          done      = 1'b1;
        end else begin
          w_state_d = FailState;
        end
      end
`ifdef MULT_CONTROL_ERR_EN
      StErr: begin
        if (start) begin
          w_state_d = StLsb;
          clk_ena   = 1'b1;
          sclr_n    = 1'b0;
        end
      end
`endif
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Reset masks every output, including the debug state code.
    if (reset_a) begin
      input_sel = 2'b00;
      shift_sel = 2'b00;
      done      = 1'b0;
      clk_ena   = 1'b0;
      sclr_n    = 1'b1;
      state_out = 3'b000;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: directed vector table followed by randomized cycles against a model.
module tb_mult_control;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       start;
  logic [1:0] count;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic [2:0] state_out;
  logic       done;
  logic       clk_ena;
  logic       sclr_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_control dut (
    .clk      (clk),
    .reset_a  (reset_a),
    .start    (start),
    .count    (count),
    .input_sel(input_sel),
    .shift_sel(shift_sel),
    .state_out(state_out),
    .done     (done),
    .clk_ena  (clk_ena),
    .sclr_n   (sclr_n)
  );

`ifdef MULT_CONTROL_ERR_EN
  localparam logic [2:0] E = 3'd5;
`else
  localparam logic [2:0] E = 3'd0;
`endif

  // Output bundle: {state_out, input_sel, shift_sel, done, clk_ena, sclr_n}
  typedef struct packed {
    logic       rst;
    logic       st;
    logic [1:0] cnt;
    logic [2:0] so;
    logic [1:0] isel;
    logic [1:0] ssel;
    logic       dn;
    logic       ena;
    logic       scl;
  } vec_t;

  vec_t tbl[28];

  function automatic logic [9:0] pack_out(logic [2:0] so, logic [1:0] is, logic [1:0] ss,
                                          logic dn, logic en, logic sc);
    return {so, is, ss, dn, en, sc};
  endfunction

  task automatic check(input string name, input logic [9:0] req);
    logic [9:0] act;
    act = {state_out, input_sel, shift_sel, done, clk_ena, sclr_n};
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got {st,isel,ssel,done,ena,scl}=%b_%b_%b_%b%b%b required %b_%b_%b_%b%b%b",
               name, act[9:7], act[6:5], act[4:3], act[2], act[1], act[0],
               req[9:7], req[6:5], req[4:3], req[2], req[1], req[0]);
    end
  endtask

  // Model phase: 0 idle, 1 lsb, 2 mid, 3 msb, 4 calc done, 5 err
  int m_phase = 0;

  task automatic model(input logic rst, input logic st, input logic [1:0] cnt,
                       output logic [9:0] exp, output int nxt);
    logic [1:0] acc_sel;
    logic       accept;
    exp = pack_out(3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    nxt = m_phase;
    if (rst) begin
      nxt = 0;
      return;
    end
    exp[9:7] = 3'(m_phase);
    if (m_phase == 0 || m_phase == 5) begin
      if (st) begin
        exp[1] = 1'b1;
        exp[0] = 1'b0;
        nxt    = 1;
      end
    end else if (m_phase == 4) begin
      if (!st) begin
        exp[2] = 1'b1;
        nxt    = 0;
      end else begin
        nxt = int'(E);
      end
    end else begin
      // Accepted counts: lsb wants 0, mid wants 1 (stay) or 2, msb wants 3.
      accept = !st && ((m_phase == 1 && cnt == 2'd0) ||
                       (m_phase == 2 && (cnt == 2'd1 || cnt == 2'd2)) ||
                       (m_phase == 3 && cnt == 2'd3));
      if (accept) begin
        acc_sel  = cnt;
        exp[6:5] = acc_sel;
        exp[4:3] = 2'(int'(acc_sel[0]) + int'(acc_sel[1]));
        exp[1]   = 1'b1;
        nxt      = (m_phase == 2 && cnt == 2'd1) ? 2 : m_phase + 1;
      end else begin
        nxt = int'(E);
      end
    end
  endtask

  initial begin
    logic [9:0] exp;
    int         nxt;
    int         r;

    //          rst   st    cnt   so    isel  ssel  dn    ena   scl
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 2'd1, 3'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 2'd2, 3'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 2'd3, 3'd3, 2'd3, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 3'd4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 3'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'd2, 3'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 2'd3, 3'd3, 2'd3, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 3'd4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 2'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 2'd0, E,    2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 2'd0, E,    2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 2'd0, E,    2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 2'd2, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 2'd0, E,    2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[22] = '{1'b0, 1'b1, 2'd0, E,    2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 2'd1, 3'd2, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[25] = '{1'b0, 1'b0, 2'd2, 3'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[26] = '{1'b1, 1'b0, 2'd3, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[27] = '{1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};

    // Inputs change just after the rising edge; outputs sampled on the falling edge.
    reset_a = 1'b1;
    start   = 1'b0;
    count   = 2'd0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      reset_a = tbl[i].rst;
      start   = tbl[i].st;
      count   = tbl[i].cnt;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            pack_out(tbl[i].so, tbl[i].isel, tbl[i].ssel, tbl[i].dn, tbl[i].ena, tbl[i].scl));
      @(posedge clk);
      #1;
    end

    m_phase = 0;
    for (int c = 0; c < 3000; c++) begin
      r       = int'($urandom_range(0, 99));
      reset_a = (r < 2);
      r       = int'($urandom_range(0, 99));
      if (m_phase == 0 || m_phase == 5) start = (r < 30);
      else start = (r < 5);
      r = int'($urandom_range(0, 99));
      if (r < 85) begin
        case (m_phase)
          1:       count = 2'd0;
          2:       count = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
          3:       count = 2'd3;
          default: count = 2'($urandom_range(0, 3));
        endcase
      end else begin
        count = 2'($urandom_range(0, 3));
      end
      model(reset_a, start, count, exp, nxt);
      @(negedge clk);
      check($sformatf("rand%0d", c), exp);
      m_phase = nxt;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_control.md
# mult_control

Control state machine for the 8x8 sequential multiplier built around a single 4x4 multiplier and a shifting accumulator. It sequences the four partial products (lo·lo, hi·lo, lo·hi, hi·hi) over four clock cycles. It drives the operand-nibble select, the partial-product shift amount, the accumulator enable and clear, and a one-cycle completion pulse. An external 2-bit cycle counter supplies `count`; that counter advances on `clk_ena` and clears on `sclr_n`.

## Interface
- No parameters.
- Clocking: one clock; reset is synchronous and active-high. Ports are `clk` and `reset_a`.
- `clk`  in  1  rising-edge clock.
- `reset_a`  in  1  synchronous, active-high reset; forces state IDLE.
- `start`  in  1  begin-multiply request; must be high for exactly one cycle.
- `count`  in  2  partial-product index from the external counter.
- `input_sel`  out  2  operand nibble select: bit1 selects the b nibble, bit0 selects the a nibble (0=lo, 1=hi).
- `shift_sel`  out  2  partial-product shift: 00=<<0, 01=<<4, 10=<<8, 11 unused.
- `state_out`  out  3  current state encoding, for debug and seven-segment display.
- `done`  out  1  result-valid pulse.
- `clk_ena`  out  1  accumulator/counter enable.
- `sclr_n`  out  1  active-low synchronous clear of accumulator and counter.

## Operation
- States and `state_out` encoding: IDLE=000, LSB=001, MID=010, MSB=011, CALC_DONE=100, ERR=101. Codes 110 and 111 are illegal and recover to IDLE on the next clock.
- Outputs are Mealy: combinational from (state, start, count).
- Output defaults unless a row below sets them: `input_sel`=00, `shift_sel`=00, `done`=0, `clk_ena`=0, `sclr_n`=1.
- IDLE:
  - start=1 -> LSB, with `clk_ena`=1 and `sclr_n`=0.
  - Otherwise stay in IDLE.
- LSB:
  - start=0 and count=00 -> MID, with `input_sel`=00, `shift_sel`=00, `clk_ena`=1.
  - Otherwise -> ERR.
- MID:
  - start=0 and count=01 -> stay in MID, with `input_sel`=01, `shift_sel`=01, `clk_ena`=1.
  - start=0 and count=10 -> MSB, with `input_sel`=10, `shift_sel`=01, `clk_ena`=1.
  - Otherwise -> ERR.
- MSB:
  - start=0 and count=11 -> CALC_DONE, with `input_sel`=11, `shift_sel`=10, `clk_ena`=1.
  - Otherwise -> ERR.
- CALC_DONE:
  - start=0 -> IDLE, with `done`=1.
  - start=1 -> ERR.
- ERR:
  - start=1 -> LSB, with `clk_ena`=1 and `sclr_n`=0 (restart).
  - Otherwise stay in ERR, outputs at defaults.
- Arithmetic: no arithmetic inside the block. Product = Σ (a_sel·b_sel) << shift, accumulated outside.

## Timing
- Reset: while `reset_a`=1, all outputs are forced to defaults and `state_out`=000, regardless of `start`. State is IDLE after the clock edge.
- Reset mid-operation aborts immediately, with no `done` pulse.
- Normal latency is six cycles:
  - start cycle (IDLE)
  - LSB, MID(count 01), MID(count 10), MSB
  - CALC_DONE, where `done`=1 for exactly one cycle
  - then IDLE.
- `start` held high past one cycle, or any count mismatch, enters ERR. ERR is sticky until the next `start` pulse.
- Simultaneous `reset_a` and `start`: reset wins.

## Configuration
- `MULT_CONTROL_ERR_EN`:
  - Defined: behaviour as above; sequence violations enter ERR, and ERR is sticky until `start`.
  - Undefined: ERR is never entered. Every "-> ERR" transition goes instead to IDLE with outputs at defaults, and the ERR-exit logic is omitted. Encoding 101 becomes illegal and recovers to IDLE.

## Test plan
- Reset: `reset_a`=1 with `start`=1 for 2 cycles -> `state_out`=000, `clk_ena`=0, `sclr_n`=1, `done`=0 throughout.
- Normal multiply: `start` pulse, then count 00,01,10,11 -> `state_out` sequence 001,010,010,011,100,000.
  - `input_sel` 00,01,10,11 and `shift_sel` 00,01,01,10 with `clk_ena`=1 on those four cycles.
  - `done`=1 only in the CALC_DONE cycle.
- Start handling: `sclr_n`=0 and `clk_ena`=1 exactly in the IDLE cycle where `start`=1. `start` held 2 cycles -> `state_out`=101 (ERR). With the macro undefined, the same stimulus gives 000.
- Count mismatch: in LSB drive count=10 -> ERR. Holding `start`=0 keeps `state_out`=101 with all outputs at defaults. A `start` pulse then gives LSB with `sclr_n`=0.
- Reset mid-run: assert `reset_a` in MSB -> next `state_out`=000, `done` never asserted.
- Back-to-back: a `start` pulse on the cycle after CALC_DONE starts a second multiply with an identical output sequence.
